fifo_fwft_read_adapter: RTL
===========================

# fifo_fwft_read_adapter

- Sits on the read side of the asynchronous FIFO, between the read-mode half controller, the dual-port RAM read port and the downstream consumer.
- Drives the controller's increment request and tracks reads still in the RAM pipeline.
- Captures RAM output words into a small skid buffer.
- Presents them as a first-word-fall-through valid/ready stream, so the consumer never deals with RAM read latency or the controller's empty flag.

## Interface
Parameters:
- DATA_WIDTH, 32, width of RAM words and output data.
- RAM_LATENCY, 1, cycles from an accepted read to data on ram_dout; legal range 1..4.
- Local BUF_DEPTH = RAM_LATENCY+2: skid buffer entries.
- Local CNT_W = clog2(BUF_DEPTH+1).

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  read-domain clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ctrl_empty  in  1  controller empty/state flag; 1 = no readable word.
- ctrl_inc  out  1  read request to controller inc.
- ram_dout  in  DATA_WIDTH  RAM read data.
- m_valid  out  1  output word available.
- m_ready  in  1  consumer accepts word.
- m_data  out  DATA_WIDTH  head word of skid buffer.
- occupancy  out  CNT_W  words held in skid buffer.
- err_overflow  out  1  sticky; RAM data arrived with buffer full.

## Operation
Read issue:
- issue = ctrl_inc & ~ctrl_empty. This mirrors the controller's RAM enable; ctrl_inc while ctrl_empty=1 is harmless and does not count.
- ctrl_inc = (occupancy + inflight_count) < BUF_DEPTH, with both terms registered.
- There is no combinational path from m_ready or ctrl_empty to ctrl_inc.

In-flight tracking:
- RAM_LATENCY-bit shift register; bit 0 loads issue each cycle.
- inflight_count = popcount of the shift register.
- The top bit set means ram_dout is valid this cycle (ret).

Skid buffer:
- Circular buffer of BUF_DEPTH entries with write pointer, read pointer and count.
- Push on ret; pop on m_valid & m_ready.
- Pointers wrap modulo BUF_DEPTH, which is not a power of two: compare to BUF_DEPTH-1 and reset to 0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push when count==BUF_DEPTH and no pop: word dropped, err_overflow set until reset. Unreachable by construction; verification must show it never fires.

Output:
- m_valid = (count != 0); m_data = entry[rd_ptr]; occupancy = count.
- m_data is stable while m_valid=1 and m_ready=0.

Reset (rst_n=0 sampled on a rising edge):
- Pointers, count, in-flight register and err_overflow clear.
- m_valid=0, occupancy=0, ctrl_inc=0 during and in the cycle after reset.
- Buffered and in-flight words are discarded. The read half controller must be reset in the same cycle (top level inverts rst_n) so its pointer matches.

## Timing
- Issue in cycle t: ram_dout sampled at the end of cycle t+RAM_LATENCY; m_valid=1 in cycle t+RAM_LATENCY+1.
- First word after FIFO becomes non-empty: m_valid rises RAM_LATENCY+1 cycles after the first cycle with ctrl_inc=1 and ctrl_empty=0.
- Sustained throughput: one word per cycle with m_ready held 1 and FIFO non-empty, for every legal RAM_LATENCY.
- Backpressure: with m_ready=0, issue stops once occupancy+inflight reaches BUF_DEPTH. The skid absorbs all in-flight words and none are lost.
- m_ready deasserted: m_data holds; on reassertion the words drain in order, one per cycle.
- ctrl_empty asserting mid-stream: issue stops immediately; buffered and in-flight words still drain; no bubbles are inserted into the data order.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with ctrl_empty=0, then release. Require m_valid=0, occupancy=0, ctrl_inc=0 during reset and the following cycle, and no issue until ctrl_inc=1.
- Streaming: RAM_LATENCY=1, RAM model returns 0..15, m_ready=1. Require m_data 0..15 on 16 consecutive cycles, the first valid 2 cycles after the first issue, and no gaps.
- Backpressure: RAM_LATENCY=3, m_ready=0 for 20 cycles. Require at most 5 issues, occupancy=5, and err_overflow=0. Then set m_ready=1 and require the words in order with stalls only until refill.
- Empty boundary: FIFO holds 2 words, then ctrl_empty=1. Require exactly 2 output words and m_valid=0 afterwards. Then ctrl_empty=0 with word 0xA5: require m_data=0xA5 RAM_LATENCY+1 cycles after issue.
- Random ready: m_ready random at 50%, RAM_LATENCY ∈ {1,2,4}, 1000 words. Require in-order, loss-free, duplicate-free delivery, err_overflow=0, and occupancy ≤ BUF_DEPTH always.
- Reset mid-operation: assert rst_n=0 with occupancy=3 and 1 word in flight. Require the next cycle to show m_valid=0 and occupancy=0, and the returning in-flight word to be ignored, not pushed.

Source files
------------

// File: rtl/fifo_fwft_read_adapter.sv
// Read-side adapter for the async FIFO: issues reads to the half controller, tracks words
// in the RAM read pipeline and re-presents them as a first-word-fall-through valid/ready stream.
module fifo_fwft_read_adapter #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int RAM_LATENCY = 1,
    localparam int BUF_DEPTH   = RAM_LATENCY + 2,
    localparam int CNT_W       = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_empty,
    output logic                  ctrl_inc,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_W-1:0]      occupancy,
    output logic                  err_overflow
);
    localparam int               PTR_W    = $clog2(BUF_DEPTH);
    localparam int               SUM_W    = CNT_W + 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    logic                   r_inc_en;
    logic [RAM_LATENCY-1:0] r_inflight;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_err;
    logic [DATA_WIDTH-1:0]  r_mem [BUF_DEPTH];

    logic                   w_issue;
    logic                   w_ret;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic [CNT_W-1:0]       w_inflight_cnt;
    logic [SUM_W-1:0]       w_committed;
    logic [RAM_LATENCY-1:0] w_inflight_next;

    // Depth is not a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            w_inflight_cnt = w_inflight_cnt + CNT_W'(r_inflight[i]);
        end
    end

    always_comb begin
        w_inflight_next    = r_inflight << 1;
        w_inflight_next[0] = w_issue;
    end

    // Only registered terms feed the request, so the skid always has room for every
    // word already committed to the RAM pipeline.
    assign w_committed = SUM_W'(r_count) + SUM_W'(w_inflight_cnt);
    assign ctrl_inc    = r_inc_en && (w_committed < SUM_W'(BUF_DEPTH));
    assign w_issue     = ctrl_inc & ~ctrl_empty;
    assign w_ret       = r_inflight[RAM_LATENCY-1];
    assign w_pop       = (r_count != '0) && m_ready;
    assign w_full      = (r_count == FULL_CNT);
    assign w_push      = w_ret && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inc_en   <= 1'b0;
            r_inflight <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_inc_en   <= 1'b1;
            r_inflight <= w_inflight_next;
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_ret && w_full && !w_pop) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ram_dout;
        end
    end

    assign m_valid      = (r_count != '0);
    assign m_data       = r_mem[r_rd_ptr];
    assign occupancy    = r_count;
    assign err_overflow = r_err;

endmodule
